sweep_sequencer: RTL and testbench

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

---
 rtl/sweep_pkg.sv | 21 ++
 rtl/sweep_sequencer_acc_dpram.sv | 49 ++++
 rtl/sweep_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_sweep_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep sequencer: controller states,
// commit pipeline stages and the default accumulator width.
package sweep_pkg;

  localparam int ACC_GUARD_BITS    = 8;
  localparam int ACC_WIDTH_DEFAULT = 32 + ACC_GUARD_BITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAITLOW = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    CS_IDLE = 2'd0,
    CS_C1   = 2'd1,
    CS_C2   = 2'd2
  } commit_stage_t;

endpackage

// File: rtl/sweep_sequencer_acc_dpram.sv
// Accumulator storage: port A is the commit read/modify/write port, port B a
// read-only system port. Both reads are registered; contents are not reset.
module acc_dpram
  import sweep_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEFAULT
) (
  input  logic                  clk125,
  input  logic                  a_rd_en,
  input  logic                  a_wr_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ACC_WIDTH-1:0]  a_wmod,
  input  logic [ACC_WIDTH-1:0]  a_wphase,
  output logic [ACC_WIDTH-1:0]  a_rmod,
  output logic [ACC_WIDTH-1:0]  a_rphase,
  input  logic                  b_rd_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [ACC_WIDTH-1:0]  b_rmod,
  output logic [ACC_WIDTH-1:0]  b_rphase
);

  logic [2*ACC_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
  logic [2*ACC_WIDTH-1:0] a_q_r;
  logic [2*ACC_WIDTH-1:0] b_q_r;

  // Commit port: write and registered read at the same address
  always_ff @(posedge clk125) begin
    if (a_wr_en) begin
      mem_r[a_addr] <= {a_wmod, a_wphase};
    end
    if (a_rd_en) begin
      a_q_r <= mem_r[a_addr];
    end
  end

  // System read port
  always_ff @(posedge clk125) begin
    if (b_rd_en) begin
      b_q_r <= mem_r[b_addr];
    end
  end

  assign a_rmod   = a_q_r[2*ACC_WIDTH-1:ACC_WIDTH];
  assign a_rphase = a_q_r[ACC_WIDTH-1:0];
  assign b_rmod   = b_q_r[2*ACC_WIDTH-1:ACC_WIDTH];
  assign b_rphase = b_q_r[ACC_WIDTH-1:0];

endmodule

// File: rtl/sweep_sequencer.sv
// Multi-sweep run controller: pairs magnitude/phase results from the sweep
// engine and accumulates them per frequency point across sweeps.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + ACC_GUARD_BITS
) (
  input  logic                  clk125,
  input  logic                  areset_n,
  input  logic                  cmd_start,
  input  logic                  cmd_abort,
  input  logic [7:0]            num_sweeps,
  input  logic [ADDR_WIDTH-1:0] num_points,
  output logic                  eng_start,
  input  logic                  eng_fin,
  input  logic                  res_valid_m,
  input  logic [DATA_WIDTH-1:0] res_modulo,
  input  logic                  res_valid_p,
  input  logic [DATA_WIDTH-1:0] res_phase,
  input  logic [ADDR_WIDTH-1:0] res_index,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ACC_WIDTH-1:0]  rd_mod_sum,
  output logic [ACC_WIDTH-1:0]  rd_phase_sum,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            sweep_count,
  output logic                  err_overrun,
  output logic                  err_short
);

  seq_state_t            state_r, state_s;
  commit_stage_t         stage_r;
  logic                  m_pend_r, p_pend_r;
  logic [DATA_WIDTH-1:0] m_val_r, p_val_r, cm_mod_r, cm_phase_r;
  logic [ADDR_WIDTH-1:0] m_idx_r, cm_idx_r;
  logic [7:0]            sweep_count_r;
  logic [ADDR_WIDTH:0]   points_seen_r;
  logic                  eng_start_r, busy_r, done_r, rd_valid_r;
  logic                  err_overrun_r, err_short_r;
  logic                  active_s, take_m_s, take_p_s, launch_s, wr_en_s, fin_go_s;
  logic                  start_run_s, to_waitlow_s, wl_exit_s;
  logic [8:0]            sweep_inc_s, sweep_tgt_s;
  logic [ACC_WIDTH-1:0]  old_mod_s, old_phase_s, new_mod_s, new_phase_s;
  logic [ACC_WIDTH-1:0]  wr_mod_s, wr_phase_s;

  assign active_s    = (state_r == ST_RUN) || (state_r == ST_WAITLOW);
  assign take_m_s    = active_s && res_valid_m && !cmd_abort;
  assign take_p_s    = active_s && res_valid_p && !cmd_abort;
  // A pair is handed to the commit pipeline only while it is empty, which
  // guarantees each C1 read sees the previous C2 write.
  assign launch_s    = m_pend_r && p_pend_r && (stage_r == CS_IDLE) && !cmd_abort;
  assign wr_en_s     = (stage_r == CS_C2) && !cmd_abort;
  assign fin_go_s    = eng_fin && !(m_pend_r && p_pend_r) && (stage_r == CS_IDLE);
  assign sweep_inc_s = {1'b0, sweep_count_r} + 9'd1;
  assign sweep_tgt_s = (num_sweeps == 8'd0) ? 9'd1 : {1'b0, num_sweeps};

  assign new_mod_s   = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, cm_mod_r};
  assign new_phase_s = {{(ACC_WIDTH-DATA_WIDTH){cm_phase_r[DATA_WIDTH-1]}}, cm_phase_r};
  assign wr_mod_s    = (sweep_count_r == 8'd0) ? new_mod_s   : old_mod_s + new_mod_s;
  assign wr_phase_s  = (sweep_count_r == 8'd0) ? new_phase_s : old_phase_s + new_phase_s;

  // Next-state decode for the run controller
  always_comb begin
    state_s      = state_r;
    start_run_s  = 1'b0;
    to_waitlow_s = 1'b0;
    wl_exit_s    = 1'b0;
    if (cmd_abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (cmd_start) begin
            state_s     = ST_RUN;
            start_run_s = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
        ST_RUN: begin
          if (fin_go_s) begin
            state_s      = ST_WAITLOW;
            to_waitlow_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_WAITLOW: begin
          if (!eng_fin) begin
            wl_exit_s = 1'b1;
            state_s   = (sweep_inc_s >= sweep_tgt_s) ? ST_DONE : ST_RUN;
          end else begin
            state_s = ST_WAITLOW;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register with outputs decoded from the next state
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      state_r     <= ST_IDLE;
      eng_start_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      eng_start_r <= (state_s == ST_RUN);
      busy_r      <= (state_s == ST_RUN) || (state_s == ST_WAITLOW);
      done_r      <= (state_s == ST_DONE);
      rd_valid_r  <= rd_en;
    end
  end

  // Sweep/point counters and sticky error flags
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      sweep_count_r <= 8'd0;
      points_seen_r <= {(ADDR_WIDTH+1){1'b0}};
      err_overrun_r <= 1'b0;
      err_short_r   <= 1'b0;
    end else if (start_run_s) begin
      sweep_count_r <= 8'd0;
      points_seen_r <= {(ADDR_WIDTH+1){1'b0}};
      err_overrun_r <= 1'b0;
      err_short_r   <= 1'b0;
    end else begin
      if (wl_exit_s) begin
        sweep_count_r <= sweep_count_r + 8'd1;
      end
      if (to_waitlow_s) begin
        points_seen_r <= {(ADDR_WIDTH+1){1'b0}};
        if (points_seen_r != {1'b0, num_points}) begin
          err_short_r <= 1'b1;
        end
      end else if (wr_en_s) begin
        points_seen_r <= points_seen_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      // Overwriting a value that is being copied out this cycle loses nothing
      if (!launch_s && ((take_m_s && m_pend_r) || (take_p_s && p_pend_r))) begin
        err_overrun_r <= 1'b1;
      end
    end
  end

  // Pending-result capture; a strobe in the launch cycle re-arms its flag
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      m_pend_r <= 1'b0;
      p_pend_r <= 1'b0;
      m_val_r  <= {DATA_WIDTH{1'b0}};
      p_val_r  <= {DATA_WIDTH{1'b0}};
      m_idx_r  <= {ADDR_WIDTH{1'b0}};
    end else if (cmd_abort || start_run_s) begin
      m_pend_r <= 1'b0;
      p_pend_r <= 1'b0;
    end else begin
      m_pend_r <= take_m_s || (m_pend_r && !launch_s);
      p_pend_r <= take_p_s || (p_pend_r && !launch_s);
      if (take_m_s) begin
        m_val_r <= res_modulo;
        m_idx_r <= res_index;
      end
      if (take_p_s) begin
        p_val_r <= res_phase;
      end
    end
  end

  // Two-stage commit pipeline: C1 reads the old sums, C2 writes the new ones
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      stage_r    <= CS_IDLE;
      cm_mod_r   <= {DATA_WIDTH{1'b0}};
      cm_phase_r <= {DATA_WIDTH{1'b0}};
      cm_idx_r   <= {ADDR_WIDTH{1'b0}};
    end else if (cmd_abort) begin
      stage_r <= CS_IDLE;
    end else begin
      case (stage_r)
        CS_IDLE: begin
          if (launch_s) begin
            stage_r    <= CS_C1;
            cm_mod_r   <= m_val_r;
            cm_phase_r <= p_val_r;
            cm_idx_r   <= m_idx_r;
          end
        end
        CS_C1:   stage_r <= CS_C2;
        CS_C2:   stage_r <= CS_IDLE;
        default: stage_r <= CS_IDLE;
      endcase
    end
  end

  acc_dpram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk125  (clk125),
    .a_rd_en (stage_r == CS_C1),
    .a_wr_en (wr_en_s),
    .a_addr  (cm_idx_r),
    .a_wmod  (wr_mod_s),
    .a_wphase(wr_phase_s),
    .a_rmod  (old_mod_s),
    .a_rphase(old_phase_s),
    .b_rd_en (rd_en),
    .b_addr  (rd_addr),
    .b_rmod  (rd_mod_sum),
    .b_rphase(rd_phase_sum)
  );

  assign eng_start   = eng_start_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign rd_valid    = rd_valid_r;
  assign sweep_count = sweep_count_r;
  assign err_overrun = err_overrun_r;
  assign err_short   = err_short_r;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer: directed vector table, hand-written
// pairing/abort sequences and randomized runs against a per-point sum model.
module tb_sweep_sequencer;

  logic        clk125 = 1'b0;
  logic        areset_n;
  logic        cmd_start, cmd_abort;
  logic [7:0]  num_sweeps, num_points;
  logic        eng_start, eng_fin;
  logic        res_valid_m, res_valid_p;
  logic [31:0] res_modulo, res_phase;
  logic [7:0]  res_index;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [39:0] rd_mod_sum, rd_phase_sum;
  logic        rd_valid, busy, done, err_overrun, err_short;
  logic [7:0]  sweep_count;

  int total = 0;
  int bad   = 0;

  logic [39:0] mdl_mod [256];
  logic [39:0] mdl_ph  [256];
  int          cur_idx [8];
  logic [31:0] cur_m   [8];
  logic [31:0] cur_p   [8];

  typedef struct {
    int          nsw, npts, cnt;
    int          idx [3];
    logic [31:0] m   [3];
    logic [31:0] p   [3];
    int          raddr;
    logic [39:0] emod, eph;
    int          esc;
    bit          eshort;
  } vec_t;
  vec_t tbl [5];

  sweep_sequencer dut (
    .clk125(clk125), .areset_n(areset_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .num_sweeps(num_sweeps), .num_points(num_points), .eng_start(eng_start), .eng_fin(eng_fin),
    .res_valid_m(res_valid_m), .res_modulo(res_modulo), .res_valid_p(res_valid_p),
    .res_phase(res_phase), .res_index(res_index), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_mod_sum(rd_mod_sum), .rd_phase_sum(rd_phase_sum), .rd_valid(rd_valid),
    .busy(busy), .done(done), .sweep_count(sweep_count),
    .err_overrun(err_overrun), .err_short(err_short)
  );

  always #4 clk125 = ~clk125;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk125);
  endtask

  task automatic wait_eng(input logic lvl);
    int n = 0;
    while (eng_start !== lvl && n < 200) begin
      cycle();
      n++;
    end
    check("eng_start_wait", eng_start, lvl);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    check("done_wait", done, 1'b1);
  endtask

  task automatic send(input bit m, input bit p, input int idx, input logic [31:0] mv, input logic [31:0] pv);
    res_valid_m = m;
    res_valid_p = p;
    res_index   = idx[7:0];
    res_modulo  = mv;
    res_phase   = pv;
    cycle();
    res_valid_m = 1'b0;
    res_valid_p = 1'b0;
  endtask

  task automatic send_pair(input int idx, input logic [31:0] mv, input logic [31:0] pv, input int ord);
    case (ord)
      0: begin send(1'b1, 1'b0, idx, mv, pv); send(1'b0, 1'b1, idx, mv, pv); end
      1: begin send(1'b0, 1'b1, idx, mv, pv); send(1'b1, 1'b0, idx, mv, pv); end
      default: send(1'b1, 1'b1, idx, mv, pv);
    endcase
    repeat (4) cycle();
  endtask

  // Reference: first sweep stores the raw pair, later sweeps add (mod 2**40)
  task automatic model_commit(input int s, input int idx, input logic [31:0] mv, input logic [31:0] pv);
    logic [39:0] em, ep;
    em = {8'h00, mv};
    ep = {{8{pv[31]}}, pv};
    if (s == 0) begin
      mdl_mod[idx] = em;
      mdl_ph[idx]  = ep;
    end else begin
      mdl_mod[idx] = mdl_mod[idx] + em;
      mdl_ph[idx]  = mdl_ph[idx] + ep;
    end
  endtask

  task automatic begin_run(input int nsw, input int npts);
    num_sweeps = nsw[7:0];
    num_points = npts[7:0];
    cmd_start  = 1'b1;
    cycle();
    cmd_start  = 1'b0;
  endtask

  task automatic end_sweep();
    repeat (4) cycle();
    eng_fin = 1'b1;
    wait_eng(1'b0);
    eng_fin = 1'b0;
    cycle();
  endtask

  task automatic do_run(input int nsw, input int npts, input int cnt, input bit rnd);
    int          eff, ord;
    logic [31:0] mv, pv;
    eff = (nsw == 0) ? 1 : nsw;
    begin_run(nsw, npts);
    for (int s = 0; s < eff; s++) begin
      wait_eng(1'b1);
      for (int k = 0; k < cnt; k++) begin
        mv  = rnd ? $urandom : cur_m[k];
        pv  = rnd ? $urandom : cur_p[k];
        ord = rnd ? int'($urandom_range(0, 2)) : 0;
        send_pair(cur_idx[k], mv, pv, ord);
        model_commit(s, cur_idx[k], mv, pv);
      end
      end_sweep();
    end
    wait_done();
  endtask

  task automatic rd(input int addr, output logic [39:0] m, output logic [39:0] ph, output logic v);
    rd_en   = 1'b1;
    rd_addr = addr[7:0];
    cycle();
    rd_en   = 1'b0;
    m  = rd_mod_sum;
    ph = rd_phase_sum;
    v  = rd_valid;
  endtask

  task automatic rd_check(input string nm, input int addr, input logic [39:0] em, input logic [39:0] ep);
    logic [39:0] m, ph;
    logic        v;
    rd(addr, m, ph, v);
    check({nm, "_rd_valid"}, v, 1'b1);
    check({nm, "_mod"}, m, em);
    check({nm, "_phase"}, ph, ep);
  endtask

  initial begin
    logic [39:0] m, ph;
    logic        v;
    int          npts, cnt, nsw;

    tbl[0] = '{nsw:1, npts:3, cnt:3, idx:'{0, 1, 2},
               m:'{32'd100, 32'd200, 32'd300}, p:'{32'hFFFF_FFCE, 32'd10, 32'd0},
               raddr:1, emod:40'd200, eph:40'd10, esc:1, eshort:1'b0};
    tbl[1] = '{nsw:3, npts:1, cnt:1, idx:'{5, 0, 0},
               m:'{32'd7, 32'd0, 32'd0}, p:'{32'hFFFF_FFFE, 32'd0, 32'd0},
               raddr:5, emod:40'd21, eph:40'hFF_FFFF_FFFA, esc:3, eshort:1'b0};
    tbl[2] = '{nsw:1, npts:4, cnt:3, idx:'{8, 9, 10},
               m:'{32'd1, 32'd2, 32'd3}, p:'{32'd4, 32'd5, 32'd6},
               raddr:10, emod:40'd3, eph:40'd6, esc:1, eshort:1'b1};
    tbl[3] = '{nsw:0, npts:2, cnt:2, idx:'{20, 21, 0},
               m:'{32'd5, 32'd6, 32'd0}, p:'{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd0},
               raddr:21, emod:40'd6, eph:40'hFF_FFFF_FFF9, esc:1, eshort:1'b0};
    tbl[4] = '{nsw:2, npts:1, cnt:1, idx:'{30, 0, 0},
               m:'{32'hFFFF_FFFF, 32'd0, 32'd0}, p:'{32'h8000_0000, 32'd0, 32'd0},
               raddr:30, emod:40'h01_FFFF_FFFE, eph:40'hFF_0000_0000, esc:2, eshort:1'b0};

    areset_n = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; num_sweeps = 8'd0; num_points = 8'd0;
    eng_fin = 1'b0; res_valid_m = 1'b0; res_valid_p = 1'b0; res_modulo = 32'd0; res_phase = 32'd0;
    res_index = 8'd0; rd_en = 1'b0; rd_addr = 8'd0;
    repeat (3) cycle();
    areset_n = 1'b1;
    cycle();

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_sweep_count", sweep_count, 8'd0);
    check("rst_err_overrun", err_overrun, 1'b0);
    check("rst_err_short", err_short, 1'b0);

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3; k++) begin
        cur_idx[k] = tbl[i].idx[k];
        cur_m[k]   = tbl[i].m[k];
        cur_p[k]   = tbl[i].p[k];
      end
      do_run(tbl[i].nsw, tbl[i].npts, tbl[i].cnt, 1'b0);
      check($sformatf("vec%0d_busy", i), busy, 1'b0);
      check($sformatf("vec%0d_sweep_count", i), sweep_count, tbl[i].esc[7:0]);
      check($sformatf("vec%0d_err_short", i), err_short, tbl[i].eshort);
      check($sformatf("vec%0d_err_overrun", i), err_overrun, 1'b0);
      rd_check($sformatf("vec%0d", i), tbl[i].raddr, tbl[i].emod, tbl[i].eph);
    end
    cycle();
    check("rd_valid_drop", rd_valid, 1'b0);

    // P then M, then M and P together in the cycle the first pair launches
    begin_run(1, 2);
    wait_eng(1'b1);
    send(1'b0, 1'b1, 0, 32'd0, 32'hFFFF_FFF7);
    send(1'b1, 1'b0, 40, 32'd77, 32'd0);
    send(1'b1, 1'b1, 41, 32'd88, 32'd5);
    repeat (6) cycle();
    end_sweep();
    wait_done();
    check("pair_err_overrun", err_overrun, 1'b0);
    check("pair_err_short", err_short, 1'b0);
    rd_check("pair40", 40, 40'd77, 40'hFF_FFFF_FFF7);
    rd_check("pair41", 41, 40'd88, 40'd5);

    // Back-to-back magnitudes: second wins, overrun flagged
    begin_run(1, 1);
    wait_eng(1'b1);
    send(1'b1, 1'b0, 50, 32'd11, 32'd0);
    send(1'b1, 1'b0, 50, 32'd12, 32'd0);
    send(1'b0, 1'b1, 0, 32'd0, 32'hFFFF_FFFD);
    repeat (4) cycle();
    end_sweep();
    wait_done();
    check("ovr_err_overrun", err_overrun, 1'b1);
    check("ovr_err_short", err_short, 1'b0);
    rd_check("ovr50", 50, 40'd12, 40'hFF_FFFF_FFFD);

    // Abort with a magnitude pending; next run must not pair with it
    begin_run(1, 1);
    wait_eng(1'b1);
    send(1'b1, 1'b0, 50, 32'd999, 32'd0);
    cmd_abort = 1'b1;
    cycle();
    cmd_abort = 1'b0;
    check("abort_eng_start", eng_start, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    begin_run(1, 1);
    wait_eng(1'b1);
    send(1'b0, 1'b1, 0, 32'd0, 32'd33);
    send(1'b1, 1'b0, 61, 32'd44, 32'd0);
    repeat (4) cycle();
    end_sweep();
    wait_done();
    check("abort_err_overrun", err_overrun, 1'b0);
    check("abort_err_short", err_short, 1'b0);
    rd_check("abort61", 61, 40'd44, 40'd33);
    rd_check("abort50", 50, 40'd12, 40'hFF_FFFF_FFFD);

    // Randomized runs against the sum model
    for (int r = 0; r < 6; r++) begin
      nsw  = int'($urandom_range(0, 3));
      npts = int'($urandom_range(1, 6));
      cnt  = ($urandom_range(0, 3) == 0) ? npts - 1 : npts;
      for (int k = 0; k < cnt; k++) cur_idx[k] = 100 + int'($urandom_range(0, 15));
      do_run(nsw, npts, cnt, 1'b1);
      check($sformatf("rnd%0d_sweep_count", r), sweep_count, (nsw == 0) ? 8'd1 : nsw[7:0]);
      check($sformatf("rnd%0d_err_short", r), err_short, cnt != npts);
      check($sformatf("rnd%0d_err_overrun", r), err_overrun, 1'b0);
      check($sformatf("rnd%0d_busy", r), busy, 1'b0);
      for (int k = 0; k < cnt; k++) begin
        rd_check($sformatf("rnd%0d_pt%0d", r, k), cur_idx[k], mdl_mod[cur_idx[k]], mdl_ph[cur_idx[k]]);
      end
    end

    // Reads while idle return the same stored values
    rd(1, m, ph, v);
    check("idle_rd_valid", v, 1'b1);
    check("idle_rd_mod", m, 40'd200);
    check("idle_rd_phase", ph, 40'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
